// File: rtl/sync_fifo_wr_arbiter.sv
// rtl/sync_fifo_wr_arbiter.sv - round-robin credit-based write arbiter for a synchronous FIFO
module sync_fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH + 1),
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        arb_en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_wr_data,
    input  logic                        fifo_rd_en,
    output logic [ID_W-1:0]             grant_id,
    output logic [CNT_W-1:0]            credit_count,
    output logic                        underflow_err
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] last_ptr;
    logic [ID_W-1:0] win_idx;
    logic            found;
    logic            space;
    logic            pop_ok;
    int unsigned     idx;

    // Space is judged on committed credit only, so a same-cycle pop never opens a grant.
    assign space  = (credit_count < DEPTH_C);
    assign pop_ok = fifo_rd_en && (credit_count != '0);

    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        idx       = 0;
        req_ready = '0;
        if (arb_en && space) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(last_ptr) + k) % NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found   = 1'b1;
                    win_idx = ID_W'(idx);
                end
            end
        end
        if (found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ptr     <= LAST_RST;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            grant_id     <= '0;
        end else begin
            fifo_wr_en <= found;
            if (found) begin
                last_ptr     <= win_idx;
                fifo_wr_data <= req_data[int'(win_idx)*DATA_W +: DATA_W];
                grant_id     <= win_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_count  <= '0;
            underflow_err <= 1'b0;
        end else begin
            case ({found, pop_ok})
                2'b10:   credit_count <= credit_count + CNT_W'(1);
                2'b01:   credit_count <= credit_count - CNT_W'(1);
                default: credit_count <= credit_count;
            endcase
            if (fifo_rd_en && (credit_count == '0)) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// tb/tb_sync_fifo_wr_arbiter.sv - self-checking bench for sync_fifo_wr_arbiter
module tb_sync_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            arb_en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    logic [N-1:0]    req_ready;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic            fifo_rd_en = 1'b0;
    logic [1:0]      grant_id;
    logic [4:0]      credit_count;
    logic            underflow_err;

    int total = 0;
    int passed = 0;

    sync_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_rd_en(fifo_rd_en), .grant_id(grant_id),
        .credit_count(credit_count), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: occupancy as a plain integer, fairness as "next valid after the last winner".
    int m_credit, m_last, m_gid, m_uf;
    int m_wr_en, m_data;

    always @(negedge clk) begin
        int w, c;
        #3;
        if (!rst_n) begin
            m_credit = 0; m_last = N - 1; m_gid = 0; m_uf = 0; m_wr_en = 0; m_data = 0;
            check("m_rst_wr_en", fifo_wr_en, 0);
            check("m_rst_credit", credit_count, 0);
            check("m_rst_uf", underflow_err, 0);
        end else begin
            w = -1;
            if (arb_en && m_credit < D) begin
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
                end
            end
            check("m_ready", req_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
            check("m_wr_en", fifo_wr_en, m_wr_en);
            check("m_wr_data", fifo_wr_data, m_data);
            check("m_grant_id", grant_id, m_gid);
            check("m_credit", credit_count, m_credit);
            check("m_uf", underflow_err, m_uf);
            c = m_credit;
            m_wr_en = (w >= 0);
            if (w >= 0) begin
                m_data = int'(req_data[w*DW +: DW]);
                m_gid = w;
                m_last = w;
            end
            m_credit = c + ((w >= 0) ? 1 : 0) - ((fifo_rd_en && c > 0) ? 1 : 0);
            if (fifo_rd_en && c == 0) m_uf = 1;
        end
    end

    task automatic drive(input logic rst, input logic [N-1:0] v, input logic en, input logic rd);
        @(negedge clk);
        rst_n = rst; req_valid = v; arb_en = en; fifo_rd_en = rd;
        #4;
    endtask

    initial begin
        logic [N-1:0] exp_rr [5];
        int grants;
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset state
        drive(0, 4'b0000, 0, 0);
        drive(0, 4'b0000, 0, 0);
        check("rst_ready", req_ready, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_data", fifo_wr_data, 0);
        check("rst_gid", grant_id, 0);
        check("rst_credit", credit_count, 0);
        check("rst_uf", underflow_err, 0);

        // round robin across all producers, write stage one cycle behind
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'b1111, 1, 0);
            check("rr_ready", req_ready, exp_rr[i]);
            if (i > 0) begin
                check("rr_wr_en", fifo_wr_en, 1);
                check("rr_gid", grant_id, i - 1);
                check("rr_data", fifo_wr_data, 8'hA0 + i - 1);
            end
        end
        drive(1, 4'b0000, 1, 0);
        check("rr_gid_last", grant_id, 0);
        check("rr_data_last", fifo_wr_data, 8'hA0);
        check("rr_credit", credit_count, 5);

        // transfer and pop in the same cycle
        drive(1, 4'b0100, 1, 1);
        check("sim_ready", req_ready, 4'b0100);
        drive(1, 4'b0000, 1, 0);
        check("sim_credit", credit_count, 5);
        check("sim_wr_en", fifo_wr_en, 1);
        check("sim_gid", grant_id, 2);
        check("sim_data", fifo_wr_data, 8'hA2);

        // drain, then fill to the full boundary from one producer
        for (int i = 0; i < 5; i++) drive(1, 4'b0000, 1, 1);
        grants = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 4'b0100, 1, 0);
            if (req_ready[2]) grants++;
        end
        check("full_grants", grants, 16);
        check("full_credit", credit_count, 16);
        check("full_ready", req_ready, 0);
        grants = 0;
        drive(1, 4'b0100, 1, 1);
        check("full_pop_ready", req_ready, 0);
        if (req_ready[2]) grants++;
        drive(1, 4'b0100, 1, 0);
        check("full_reopen_credit", credit_count, 15);
        if (req_ready[2]) grants++;
        drive(1, 4'b0100, 1, 0);
        if (req_ready[2]) grants++;
        check("full_one_more", grants, 1);
        check("full_credit2", credit_count, 16);

        // fairness between producers 1 and 3 starting from last_ptr=3
        for (int i = 0; i < 16; i++) drive(1, 4'b0000, 1, 1);
        drive(1, 4'b1000, 1, 0);
        check("fair_seed", req_ready, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'b1010, 1, 0);
            check("fair_ready", req_ready, (i % 2 == 0) ? 4'b0010 : 4'b1000);
        end

        // arb_en low blocks grants, in-flight write completes
        drive(1, 4'b1111, 0, 0);
        check("dis_ready", req_ready, 0);
        check("dis_inflight", fifo_wr_en, 1);
        drive(1, 4'b1111, 0, 0);
        check("dis_wr_en", fifo_wr_en, 0);
        check("dis_credit", credit_count, 5);

        // underflow is sticky
        for (int i = 0; i < 5; i++) drive(1, 4'b0000, 0, 1);
        drive(1, 4'b0000, 0, 1);
        check("uf_pre", underflow_err, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'b0000, 0, 0);
            check("uf_sticky", underflow_err, 1);
            check("uf_credit", credit_count, 0);
        end

        // reset in the cycle after a grant
        drive(1, 4'b1111, 1, 0);
        check("mid_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        check("mid_pre_wr_en", fifo_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("mid_wr_en", fifo_wr_en, 0);
        check("mid_credit", credit_count, 0);
        check("mid_uf", underflow_err, 0);
        drive(0, 4'b0000, 1, 0);
        drive(1, 4'b1111, 1, 0);
        check("mid_first", req_ready, 4'b0001);
        drive(1, 4'b0000, 1, 0);
        check("mid_gid", grant_id, 0);
        check("mid_wr_en2", fifo_wr_en, 1);

        drive(1, 4'b0000, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
